output_argmax: RTL and testbench
================================

# output_argmax

Sequential classifier stage at the output layer of the digit network. It consumes the ReLU'd results of the CLASS_COUNT output neurons as a valid/ready stream, one score per beat. It tracks the largest and second-largest scores and presents the winning class index, with a held valid/ready result, to the display/readout logic.

## Interface
- CLASS_COUNT, default 10: number of output neurons (scores) per frame; must be ≥ 2.
- DATA_WIDTH, default 32: score width, matches neuron result width.
- IDX_WIDTH, default $clog2(CLASS_COUNT): derived; class index width.

- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  score beat present.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  DATA_WIDTH  score; unsigned (neuron outputs are ReLU'd, never negative).
- in_last  input  1  producer marks the final score of a frame.
- out_valid  output  1  result held.
- out_ready  input  1  consumer takes the result.
- out_class  output  IDX_WIDTH  index of winning score.
- out_score  output  DATA_WIDTH  winning score value.
- out_error  output  1  frame length mismatch (see Operation).
- out_margin  output  DATA_WIDTH  best minus second-best; present only with OUTPUT_ARGMAX_MARGIN_EN.

## Operation
- Two states: SCAN and HOLD.
- SCAN:
  - in_ready = 1 and out_valid = 0.
  - A beat is accepted when in_valid && in_ready.
  - Beat index i runs 0..CLASS_COUNT-1 from an internal counter.
- Running registers: best, second, best_idx, cleared to 0 at frame start. The update rule for an accepted beat of value v is:
  - If v > best: second ← best, best ← v, best_idx ← i.
  - Else if v > second: second ← v.
- Ties resolve to the lowest index. A later equal value updates second, so the margin reads 0.
- All-zero frame → class 0, score 0.
- Comparisons are unsigned and full DATA_WIDTH. No saturation is needed. Margin subtraction cannot underflow because best ≥ second.
- Frame end is the first accepted beat with in_last = 1 OR i = CLASS_COUNT-1. On that beat:
  - Counter wraps to 0.
  - Results latch including that beat.
  - State → HOLD.
- out_error = 1 when in_last disagrees with (i == CLASS_COUNT-1) on the ending beat. This covers an early in_last, and a missing in_last on the final index. The result is still produced from the beats received.
- HOLD:
  - in_ready = 0 and out_valid = 1.
  - out_class, out_score, out_error and out_margin are stable until out_valid && out_ready.
  - On that handshake: state → SCAN, and best, second, best_idx and the counter clear.
- in_data and in_last are ignored when the beat is not accepted.

## Timing
- Reset values:
  - State SCAN, counter 0, best/second/best_idx 0.
  - out_valid 0, out_class 0, out_score 0, out_error 0, out_margin 0.
  - in_ready is 0 while rst is high and 1 in the first cycle after release.
- Latency: out_valid rises on the cycle after the ending beat is accepted.
- Accept and release:
  - The result handshake in cycle t makes in_ready = 1 in cycle t+1.
  - No beat is accepted in the same cycle as a result handshake.
- Throughput: one frame per CLASS_COUNT+1 cycles minimum, with continuous in_valid and out_ready.
- out_valid never drops without a handshake, except on rst.
- Reset mid-frame or mid-HOLD discards all partial state. The next accepted beat is index 0 of a new frame.
- Gaps in in_valid during SCAN are legal and stall the counter.

## Configuration
- OUTPUT_ARGMAX_MARGIN_EN defined:
  - The out_margin port exists.
  - It is registered at frame end as best − second and held in HOLD.
  - It is 0 after reset.
- Not defined:
  - The out_margin port and the subtractor are removed.
  - The second register is not needed and is removed.
  - All other behaviour is identical.

## Test plan
- Scores 5,9,3,9,0,0,0,0,0,1 with in_last on the 10th beat → out_class 1, out_score 9, out_error 0, out_margin 0; out_valid one cycle after the 10th accept.
- All-zero frame → out_class 0, out_score 0, out_margin 0.
- 0xFFFFFFFF at index 9, 0x7FFFFFFF at index 0, others 0 → out_class 9 (unsigned compare), out_margin 0x80000000.
- Hold out_ready low for 5 cycles after out_valid → outputs bit-stable, in_ready 0. Pulse out_ready, then run a second frame of 0,0,7,0,… → out_class 2 with no residue from frame 1.
- in_last on beat 4 with scores 1,2,8,3,4 → out_error 1, out_class 2, out_score 8. Then 10 beats without in_last → out_error 1, result still valid.
- Assert rst after 3 beats (scores 50,60,70), then send a fresh frame with max 20 at index 6 → out_class 6, out_score 20.

Source files
------------

// File: rtl/output_argmax.sv
// Streaming argmax over CLASS_COUNT output-neuron scores per frame; result held until taken.
// Optional OUTPUT_ARGMAX_MARGIN_EN adds out_margin (best minus second-best score).
module output_argmax #(
  parameter int CLASS_COUNT = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int IDX_WIDTH   = $clog2(CLASS_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_WIDTH-1:0]  out_class,
  output logic [DATA_WIDTH-1:0] out_score,
  output logic                  out_error
`ifdef OUTPUT_ARGMAX_MARGIN_EN
  ,
  output logic [DATA_WIDTH-1:0] out_margin
`endif
);

  localparam logic [0:0] SCAN = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(CLASS_COUNT - 1);

  logic [0:0]            state;
  logic [IDX_WIDTH-1:0]  cnt;
  logic [DATA_WIDTH-1:0] best;
  logic [IDX_WIDTH-1:0]  best_idx;
  logic [DATA_WIDTH-1:0] nxt_best;
  logic [IDX_WIDTH-1:0]  nxt_idx;
  logic                  accept;
  logic                  handshake;
  logic                  at_last_idx;
  logic                  frame_end;
`ifdef OUTPUT_ARGMAX_MARGIN_EN
  logic [DATA_WIDTH-1:0] second;
  logic [DATA_WIDTH-1:0] nxt_second;
`endif

  assign in_ready    = (state == SCAN) && !rst;
  assign out_valid   = (state == HOLD);
  assign accept      = in_valid && in_ready;
  assign handshake   = (state == HOLD) && out_ready;
  assign at_last_idx = (cnt == LAST_IDX);
  assign frame_end   = in_last || at_last_idx;

  // Strict greater-than keeps the lowest index on ties; an equal later value still lands in second.
  always_comb begin
    nxt_best = best;
    nxt_idx  = best_idx;
`ifdef OUTPUT_ARGMAX_MARGIN_EN
    nxt_second = second;
    if (in_data > best) begin
      nxt_second = best;
      nxt_best   = in_data;
      nxt_idx    = cnt;
    end else if (in_data > second) begin
      nxt_second = in_data;
    end
`else
    if (in_data > best) begin
      nxt_best = in_data;
      nxt_idx  = cnt;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SCAN;
      cnt       <= '0;
      best      <= '0;
      best_idx  <= '0;
      out_class <= '0;
      out_score <= '0;
      out_error <= 1'b0;
`ifdef OUTPUT_ARGMAX_MARGIN_EN
      second     <= '0;
      out_margin <= '0;
`endif
    end else if (accept) begin
      best     <= nxt_best;
      best_idx <= nxt_idx;
`ifdef OUTPUT_ARGMAX_MARGIN_EN
      second <= nxt_second;
`endif
      if (frame_end) begin
        state     <= HOLD;
        cnt       <= '0;
        out_class <= nxt_idx;
        out_score <= nxt_best;
        out_error <= (in_last != at_last_idx);
`ifdef OUTPUT_ARGMAX_MARGIN_EN
        out_margin <= nxt_best - nxt_second;
`endif
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (handshake) begin
      state    <= SCAN;
      cnt      <= '0;
      best     <= '0;
      best_idx <= '0;
`ifdef OUTPUT_ARGMAX_MARGIN_EN
      second <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_output_argmax.sv
// Bench for output_argmax: queue-based frame model checked every cycle, plus directed literal checks.
module tb_output_argmax;
  localparam int CC = 10;
  localparam int DW = 32;
  localparam int IW = $clog2(CC);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [IW-1:0] out_class;
  logic [DW-1:0] out_score;
  logic          out_error;
`ifdef OUTPUT_ARGMAX_MARGIN_EN
  logic [DW-1:0] out_margin;
`endif

  int checks = 0;
  int failures = 0;

  output_argmax #(.CLASS_COUNT(CC), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_score(out_score), .out_error(out_error)
`ifdef OUTPUT_ARGMAX_MARGIN_EN
    , .out_margin(out_margin)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: frame queue + argmax -----------------
  logic [DW-1:0] q[$];
  bit            exp_valid = 0;
  bit            exp_zero  = 1;
  int            exp_class = 0;
  logic [DW-1:0] exp_score = '0;
  bit            exp_error = 0;
  logic [DW-1:0] exp_margin = '0;

  task automatic compute_result(input bit last_flag);
    int bi = 0;
    logic [DW-1:0] sec = '0;
    for (int k = 1; k < q.size(); k++) if (q[k] > q[bi]) bi = k;
    for (int k = 0; k < q.size(); k++) if (k != bi && q[k] > sec) sec = q[k];
    exp_class  = bi;
    exp_score  = q[bi];
    exp_margin = q[bi] - sec;
    exp_error  = (last_flag != (q.size() == CC));
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("out_valid", DW'(out_valid), DW'(exp_valid));
      chk("in_ready", DW'(in_ready), DW'(!exp_valid && !rst));
      if (exp_valid || exp_zero) begin
        chk("out_class", DW'(out_class), DW'(exp_class));
        chk("out_score", out_score, exp_score);
        chk("out_error", DW'(out_error), DW'(exp_error));
`ifdef OUTPUT_ARGMAX_MARGIN_EN
        chk("out_margin", out_margin, exp_margin);
`endif
      end
      // predict effect of the coming rising edge
      if (rst) begin
        q.delete();
        exp_valid = 0; exp_zero = 1;
        exp_class = 0; exp_score = '0; exp_error = 0; exp_margin = '0;
      end else if (!exp_valid) begin
        if (in_valid) begin
          q.push_back(in_data);
          if (in_last || q.size() == CC) begin
            compute_result(in_last);
            exp_valid = 1; exp_zero = 0;
          end
        end
      end else if (out_ready) begin
        exp_valid = 0;
        q.delete();
      end
    end
  end

  // ---------------- drivers -----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input bit last);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    while (!in_ready && n < 100) begin tick(); n++; end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL send_timeout in_ready stuck low, required 1");
    end
    tick();
    in_valid = 1'b0; in_data = $urandom; in_last = $urandom_range(0, 1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 200) begin tick(); n++; end
    checks++;
    if (!out_valid) begin
      failures++;
      $display("FAIL wait_valid out_valid=0 required=1");
    end
  endtask

  task automatic take();
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] v[], input int last_at);
    for (int k = 0; k < v.size(); k++) send(v[k], k == last_at);
  endtask

  initial begin
    logic [DW-1:0] v[];
    int mode, len;
    logic [DW-1:0] mx;

    repeat (3) tick();
    rst = 1'b0;
    tick();

    // frame 1: tie at 9, lowest index wins
    v = '{5, 9, 3, 9, 0, 0, 0, 0, 0, 1};
    send_frame(v, 9);
    chk("t1_latency_valid", DW'(out_valid), 1);
    chk("t1_class", DW'(out_class), 1);
    chk("t1_score", out_score, 9);
    chk("t1_error", DW'(out_error), 0);
`ifdef OUTPUT_ARGMAX_MARGIN_EN
    chk("t1_margin", out_margin, 0);
`endif
    repeat (5) tick();
    chk("t1_hold_in_ready", DW'(in_ready), 0);
    chk("t1_hold_class", DW'(out_class), 1);
    take();

    // second frame, no residue
    v = '{0, 0, 7, 0, 0, 0, 0, 0, 0, 0};
    send_frame(v, 9);
    chk("t2_class", DW'(out_class), 2);
    chk("t2_score", out_score, 7);
    take();

    // all zero
    v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    send_frame(v, 9);
    chk("t3_class", DW'(out_class), 0);
    chk("t3_score", out_score, 0);
`ifdef OUTPUT_ARGMAX_MARGIN_EN
    chk("t3_margin", out_margin, 0);
`endif
    take();

    // unsigned compare at full width
    v = '{32'h7FFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF};
    send_frame(v, 9);
    chk("t4_class", DW'(out_class), 9);
    chk("t4_score", out_score, 32'hFFFF_FFFF);
`ifdef OUTPUT_ARGMAX_MARGIN_EN
    chk("t4_margin", out_margin, 32'h8000_0000);
`endif
    take();

    // early in_last
    v = '{1, 2, 8, 3, 4};
    send_frame(v, 4);
    chk("t5_error", DW'(out_error), 1);
    chk("t5_class", DW'(out_class), 2);
    chk("t5_score", out_score, 8);
    take();

    // missing in_last
    v = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
    send_frame(v, -1);
    chk("t6_valid", DW'(out_valid), 1);
    chk("t6_error", DW'(out_error), 1);
    chk("t6_class", DW'(out_class), 5);
    take();

    // reset mid-frame
    send(50, 0); send(60, 0); send(70, 0);
    rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
    v = '{3, 11, 0, 19, 2, 5, 20, 1, 20, 4};
    send_frame(v, 9);
    chk("t7_class", DW'(out_class), 6);
    chk("t7_score", out_score, 20);
    tick();
    rst = 1'b1; tick(); rst = 1'b0; tick();

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      mode = $urandom_range(0, 3);
      len = (mode == 2) ? $urandom_range(1, CC - 1) : CC;
      mx = (f % 2 == 0) ? DW'(7) : '1;
      for (int k = 0; k < len; k++) begin
        repeat ($urandom_range(0, 2)) tick();
        send($urandom & mx, (mode == 3) ? 1'b0 : (k == len - 1));
      end
      if ($urandom_range(0, 1) == 1) out_ready = 1'b1;
      wait_valid();
      repeat ($urandom_range(0, 3)) tick();
      take();
    end

    // continuous streaming with out_ready held high
    out_ready = 1'b1;
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < CC; k++) send($urandom_range(0, 100), k == CC - 1);
    out_ready = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
